sram_sample_prefetcher: RTL
===========================

# sram_sample_prefetcher

Upstream feeder for the audio DAC path. Reads interleaved stereo 16-bit samples (left word at even address, right word at odd address) from the external SRAM ahead of playback and buffers whole frames in a small FIFO. On each one-cycle sample tick it presents the next frame on `LData`/`RData` to the music state machine. Underruns are made visible, and end-of-song handling is built in.

## Interface
Parameters:
- `ADDR_W`, 20: SRAM address width.
- `DEPTH`, 8: FIFO depth in stereo frames; power of two, ≥2.
- `END_ADDR`, 20'hFFFFF: address of the last word of the song; odd.
- `WAIT_CYC`, 2: cycles an address is held before `SRAM_DQ` is captured; ≥1.
- `LOOP`, 0: 1 wraps to address 0 after `END_ADDR`; 0 stops.

Ports:
- `CLK` in 1: system clock; all logic on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `play` in 1: level; 1 enables fetch and output, 0 pauses both.
- `rewind` in 1: one-cycle pulse; flush FIFO, address to 0, clear `done`/`underrun`.
- `sample_tick` in 1: one-cycle strobe at the audio frame rate.
- `LData` out 16: current left sample.
- `RData` out 16: current right sample.
- `done` out 1: sticky; song consumed (LOOP=0 only).
- `underrun` out 1: sticky; a tick found the FIFO empty while playing.
- `SRAM_DQ` inout 16: always high-Z from this block.
- `SRAM_ADDR` out ADDR_W: read address.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: SRAM strobes, active-low.

## Operation
- Fetch FSM states: `IDLE`, `RD_L`, `RD_R`, `PUSH`, `END`.
- `IDLE` → `RD_L` when `play`=1, FIFO not full, and not `END`.
- `RD_L`:
  - Drive the even address with CE_N/OE_N/UB_N/LB_N = 0.
  - After `WAIT_CYC` cycles, capture `SRAM_DQ` into a left holding register.
  - Increment the address, then go to `RD_R`.
- `RD_R`: same as `RD_L` for the odd address; capture into the right register, then go to `PUSH`.
- `PUSH`:
  - Write {left, right} into the FIFO.
  - If the word just read was `END_ADDR`: with LOOP=1, set address to 0 and continue; with LOOP=0, go to `END`.
  - Otherwise return to `IDLE`.
- Address arithmetic is ADDR_W-bit unsigned and never passes `END_ADDR`.
- `WE_N` is held at 1 at all times; `SRAM_DQ` is never driven.
- In `IDLE` and `END`: CE_N = OE_N = UB_N = LB_N = 1.
- A frame fetch in progress always completes, even if `play` drops; the fetch FSM only pauses in `IDLE`.
- Output side: on `sample_tick` with `play`=1:
  - FIFO non-empty: pop the head into `LData`/`RData`.
  - FIFO empty: hold `LData`/`RData` and set `underrun`.
- `done` sets when FSM=`END`, the FIFO is empty, and a `sample_tick` arrives with `play`=1.
- While `play`=0: ticks are ignored and the outputs hold.
- `rewind` has priority over everything:
  - Next cycle: FSM=`IDLE`, address 0, FIFO empty, `done`=0, `underrun`=0.
  - Any in-flight read is abandoned and its data discarded.
  - `LData`/`RData` hold their values.

## Timing
- Reset values: `LData`=`RData`=0, `SRAM_ADDR`=0, all SRAM strobes 1, `done`=0, `underrun`=0, FIFO empty, FSM=`IDLE`.
- Word read takes `WAIT_CYC` cycles. A frame takes 2·`WAIT_CYC`+1 cycles including `PUSH`, plus 1 cycle in `IDLE` when FIFO space allows.
- Tick-to-output latency: `LData`/`RData` are registered and update on the edge following the tick cycle.
- Push and pop in the same cycle leave the occupancy unchanged and are legal when full or empty.
- A frame pushed into an empty FIFO is not poppable until the following cycle; a same-cycle tick counts as an underrun.
- Full FIFO: the FSM waits in `IDLE`; no frame is ever dropped.
- Reset asserted mid-read: all state clears asynchronously and strobes go high immediately.

## Structure
- Package `audio_pkg`:
  - `fetch_state_t` enum.
  - `stereo_frame_t` packed struct {logic [15:0] left; logic [15:0] right}.
  - Constant `SAMPLE_W`=16.
- Sub-module `sample_fifo`: synchronous FIFO of `stereo_frame_t` with depth `DEPTH`.
  - Ports: push, pop, flush, full, empty, count.
  - Pointers are log2(DEPTH) bits plus one wrap bit.
- Top contains the fetch FSM, address counter, holding registers, and output/flag logic.

## Test plan
- Reset, then `play`=1 with SRAM model words 0x1000+addr: FIFO fills to 8 frames and the FSM idles. The first tick yields `LData`=0x1000 and `RData`=0x1001 one cycle later.
- Ticks every 40 cycles for 100 frames: the output sequence is addresses 2n/2n+1 with no gaps and `underrun` stays 0.
- Ticks every cycle: the FIFO drains, `underrun` sets, and `LData`/`RData` hold the last popped values.
- `END_ADDR`=0x0F, LOOP=0, ticks until drained: 8 frames out, `SRAM_ADDR` stops at 0x0F, and `done`=1 on the next tick after the FIFO empties.
- Same as above with LOOP=1: frame 9 returns `LData`=0x1000 and `done` stays 0.
- `rewind` pulsed during `RD_R` with the FIFO half full: the next cycle shows FIFO empty and address 0; the next frame popped is 0x1000/0x1001. Asserting `RESET` mid-`RD_L` drives strobes to 1 within the same cycle.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the SRAM sample prefetcher.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_L = 3'd1,
    RD_R = 3'd2,
    PUSH = 3'd3,
    END  = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous frame FIFO. Pointers carry one extra wrap bit so that full and
// empty are distinguishable without a separate occupancy register.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  stereo_frame_t             din,
  output stereo_frame_t             dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  stereo_frame_t mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  // a pop frees a slot in the same cycle, so push+pop is legal when full
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = mem[rd_ptr[PW-1:0]];

  // read/write pointers; flush empties the FIFO in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // frame storage, no reset needed since empty gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/sram_sample_prefetcher.sv
// Prefetches interleaved stereo frames from external SRAM into a FIFO and
// hands one frame per sample tick to the playback logic.
//
// state | meaning
// IDLE  | strobes off; start a frame fetch when playing and FIFO has room
// RD_L  | even (left) address on the bus, wait then capture
// RD_R  | odd (right) address on the bus, wait then capture
// PUSH  | write captured frame into FIFO; wrap or stop at song end
// END   | song fully fetched (no loop); wait for rewind
module sram_sample_prefetcher
  import audio_pkg::*;
#(
  parameter int                ADDR_W   = 20,
  parameter int                DEPTH    = 8,
  parameter logic [ADDR_W-1:0] END_ADDR = 20'hFFFFF,
  parameter int                WAIT_CYC = 2,
  parameter bit                LOOP     = 1'b0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                play,
  input  logic                rewind,
  input  logic                sample_tick,
  output logic [SAMPLE_W-1:0] LData,
  output logic [SAMPLE_W-1:0] RData,
  output logic                done,
  output logic                underrun,
  inout  wire  [SAMPLE_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);

  localparam int              WCW       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [WCW-1:0]  WAIT_LOAD = WCW'(WAIT_CYC - 1);
  localparam int              CW        = $clog2(DEPTH) + 1;

  fetch_state_t        state;
  fetch_state_t        next_state;
  logic [ADDR_W-1:0]   addr;
  logic [WCW-1:0]      wait_cnt;
  logic                wait_done;
  logic                reading;
  logic                at_end;
  logic                tick_play;
  logic [SAMPLE_W-1:0] left_hold;
  logic [SAMPLE_W-1:0] right_hold;
  stereo_frame_t       fifo_din;
  stereo_frame_t       fifo_dout;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;

  assign reading   = (state == RD_L) || (state == RD_R);
  assign wait_done = (wait_cnt == '0);
  assign at_end    = (addr == END_ADDR);
  assign tick_play = sample_tick && play && !rewind;
  assign fifo_push = (state == PUSH) && !rewind;
  assign fifo_pop  = tick_play && !fifo_empty;
  assign fifo_din  = '{left: left_hold, right: right_hold};

  // the data bus is read-only from this block
  assign SRAM_DQ   = {SAMPLE_W{1'bz}};
  assign SRAM_WE_N = 1'b1;
  assign SRAM_ADDR = addr;

  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (rewind),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // fetch state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // fetch next-state; rewind overrides everything, a started frame always finishes
  always_comb begin
    next_state = state;
    if (rewind) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (play && !fifo_full) next_state = RD_L;
        RD_L:    if (wait_done) next_state = RD_R;
        RD_R:    if (wait_done) next_state = PUSH;
        PUSH:    next_state = (at_end && !LOOP) ? END : IDLE;
        END:     next_state = END;
        default: next_state = IDLE;
      endcase
    end
  end

  // SRAM strobes, decoded straight from state so reset releases them at once
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    if (reading) begin
      SRAM_CE_N = 1'b0;
      SRAM_OE_N = 1'b0;
      SRAM_UB_N = 1'b0;
      SRAM_LB_N = 1'b0;
    end
  end

  // address counter, access wait timer and left/right holding registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr       <= '0;
      wait_cnt   <= WAIT_LOAD;
      left_hold  <= '0;
      right_hold <= '0;
    end else if (rewind) begin
      addr     <= '0;
      wait_cnt <= WAIT_LOAD;
    end else begin
      if (reading && !wait_done) wait_cnt <= wait_cnt - WCW'(1);
      else                       wait_cnt <= WAIT_LOAD;
      if (reading && wait_done) begin
        if (state == RD_L) left_hold  <= SRAM_DQ;
        else               right_hold <= SRAM_DQ;
        // parks on the last word so the address never runs past the song
        if (!at_end) addr <= addr + ADDR_W'(1);
      end
      if ((state == PUSH) && at_end && LOOP) addr <= '0;
    end
  end

  // playback outputs and sticky status flags
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      LData    <= '0;
      RData    <= '0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else if (rewind) begin
      done     <= 1'b0;
      underrun <= 1'b0;
    end else if (tick_play) begin
      if (!fifo_empty) begin
        LData <= fifo_dout.left;
        RData <= fifo_dout.right;
      end else begin
        underrun <= 1'b1;
        if (state == END) done <= 1'b1;
      end
    end
  end

  // occupancy can never exceed the FIFO depth
  always_ff @(posedge CLK) begin
    if (!RESET) assert (fifo_count <= CW'(DEPTH));
  end

endmodule
